// File: rtl/lock_seq_ctrl.sv
// Door-lock sequencing controller: entry session, unlocked hold, failure counting and timed lockout.
// Optional START timeout is enabled by defining LOCK_TIMEOUT_EN.
module lock_seq_ctrl #(
  parameter int HOLD_CYCLES    = 5000,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ps_start,
  input  logic                             ps_end,
  input  logic                             ps_fail,
  output logic [2:0]                       state_out,
  output logic                             done,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic                             locked
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    END   = 3'b010,
    LOCK  = 3'b011
  } state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [FW-1:0]   fail_reg, fail_next, fail_inc;
  logic            done_reg, done_next;
  logic            locked_reg, locked_next;
  logic            timeout, cnt_run;
  logic            pass_evt, fail_evt, lock_exit;

`ifdef LOCK_TIMEOUT_EN
  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_run = (state_reg == END) || (state_reg == LOCK) || (state_reg == START);
`else
  assign timeout = 1'b0;
  assign cnt_run = (state_reg == END) || (state_reg == LOCK);
`endif

  // Failure count saturates so it can never wrap past MAX_FAILS.
  assign fail_inc = (fail_reg == FW'(MAX_FAILS)) ? fail_reg : fail_reg + FW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      fail_reg   <= '0;
      done_reg   <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      fail_reg   <= fail_next;
      done_reg   <= done_next;
      locked_reg <= locked_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    pass_evt   = 1'b0;
    fail_evt   = 1'b0;
    lock_exit  = 1'b0;
    case (state_reg)
      IDLE:  state_next = ps_start ? START : IDLE;
      START: begin
        if (ps_end) begin
          state_next = END;
          pass_evt   = 1'b1;
        end else if (ps_fail || timeout) begin
          fail_evt   = 1'b1;
          state_next = (fail_inc == FW'(MAX_FAILS)) ? LOCK : IDLE;
        end else begin
          state_next = START;
        end
      end
      END:   state_next = (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) ? IDLE : END;
      LOCK: begin
        if (cnt_reg == CNT_W'(LOCKOUT_CYCLES - 1)) begin
          state_next = IDLE;
          lock_exit  = 1'b1;
        end else begin
          state_next = LOCK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next    = '0;
    fail_next   = fail_reg;
    done_next   = 1'b0;
    locked_next = 1'b0;
    if (state_next == state_reg) begin
      cnt_next = cnt_run ? cnt_reg + CNT_W'(1) : cnt_reg;
    end
    if (pass_evt || lock_exit) begin
      fail_next = '0;
    end else if (fail_evt) begin
      fail_next = fail_inc;
    end
    done_next   = (state_reg == END) && (state_next == IDLE);
    locked_next = (state_next == LOCK);
  end

  assign state_out = state_reg;
  assign done      = done_reg;
  assign fail_cnt  = fail_reg;
  assign locked    = locked_reg;

endmodule
